// File: rtl/fetch_line_buffer.sv
// fetch_line_buffer: instruction fetch front end with a single 64-byte line buffer.
// Requests one cache line over the system bus, fills it beat by beat and hands
// 32-bit instructions to decode as soon as the beat that holds them has arrived.
// Optional feature macro: FETCH_LINE_REUSE_EN -- a redirect that lands in the
// completely buffered line reuses the buffer instead of refetching it.

`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 4'b0001
`endif

module fetch_line_buffer #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [63:0]               entry,
  output logic                      bus_reqcyc,
  output logic                      bus_respack,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      instr_valid,
  output logic [31:0]               instr,
  output logic [63:0]               instr_pc,
  input  logic                      instr_ready,
  input  logic                      redirect_valid,
  input  logic [63:0]               redirect_pc
);

  localparam logic [12:0] REQ_TAG = {1'b1, `SYSBUS_MEMORY, 8'h00};

  typedef enum logic [1:0] {IDLE, FETCH, FILL, DRAIN} state_e;

  state_e                    state_q, state_d;
  logic [63:0]               pc_q, pc_d;
  logic [2:0]                beat_q, beat_d;
  logic [7:0]                slot_vld_q, slot_vld_d;
  logic                      instr_valid_q, instr_valid_d;
  logic                      fill_we;
  logic [BUS_DATA_WIDTH-1:0] line_mem [8];

  logic        accept;
  logic        line_done;
  logic        redirect_hit;
  logic [63:0] redirect_word;
  logic [31:0] instr_word;
  logic        unused_bits;

  // Response tag and byte-offset bits never influence fetch.
  assign unused_bits   = ^{bus_resptag, redirect_pc[1:0], entry[1:0]};

  assign redirect_word = {redirect_pc[63:2], 2'b00};
  assign line_done     = &slot_vld_q;
  // A redirect wins over an accept in the same cycle.
  assign accept        = instr_valid_q & instr_ready & ~redirect_valid;

`ifdef FETCH_LINE_REUSE_EN
  // The buffer always holds the line of the current pc while in FILL.
  assign redirect_hit  = (state_q == FILL) && line_done &&
                         (redirect_pc[63:6] == pc_q[63:6]);
`else
  assign redirect_hit  = 1'b0;
`endif

  // Bus-side outputs are decoded from the state so reset clears them at once.
  always_comb begin
    bus_reqcyc  = (state_q == FETCH);
    bus_req     = '0;
    bus_reqtag  = '0;
    bus_respack = ((state_q == FILL) || (state_q == DRAIN)) && bus_respcyc;
    if (state_q == FETCH) begin
      bus_req    = BUS_DATA_WIDTH'({pc_q[63:6], 6'b0});
      bus_reqtag = BUS_TAG_WIDTH'(REQ_TAG);
    end
  end

  // Decode-side outputs: selected half of the slot addressed by the pc.
  assign instr_word  = pc_q[2] ? line_mem[pc_q[5:3]][63:32] : line_mem[pc_q[5:3]][31:0];
  assign instr_valid = instr_valid_q;
  assign instr       = instr_valid_q ? instr_word : 32'h0;
  // pc follows entry during reset, so the visible pc is masked until release.
  assign instr_pc    = reset ? pc_q : 64'h0;

  // Next-state logic: line fill, instruction advance and redirect handling.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    beat_d     = beat_q;
    slot_vld_d = slot_vld_q;
    fill_we    = 1'b0;

    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (bus_reqack) begin
          state_d = FILL;
          beat_d  = 3'd0;
        end
      end
      FILL: begin
        if (bus_respcyc) begin
          fill_we            = 1'b1;
          slot_vld_d[beat_q] = 1'b1;
          beat_d             = beat_q + 3'd1;
        end
        if (accept) begin
          pc_d = pc_q + 64'd4;
          // Leaving the last word of a complete line moves on to the next line.
          if ((pc_q[5:2] == 4'hF) && line_done) begin
            state_d    = FETCH;
            slot_vld_d = '0;
          end
        end
      end
      DRAIN: begin
        if (bus_respcyc) begin
          beat_d = beat_q + 3'd1;
          if (beat_q == 3'd7) state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase

    if (redirect_valid && (state_q != IDLE)) begin
      pc_d = redirect_word;
      if (!redirect_hit) begin
        slot_vld_d = '0;
        case (state_q)
          // An issued request must still be drained before the next one.
          FETCH:   state_d = bus_reqack ? DRAIN : FETCH;
          FILL:    state_d = (line_done || (bus_respcyc && (beat_q == 3'd7))) ? FETCH : DRAIN;
          default: ;
        endcase
      end
    end

    instr_valid_d = (state_d == FILL) && slot_vld_d[pc_d[5:3]];
  end

  // Control state with asynchronous active-low reset; pc tracks entry in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      pc_q          <= {entry[63:2], 2'b00};
      beat_q        <= 3'd0;
      slot_vld_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      beat_q        <= beat_d;
      slot_vld_q    <= slot_vld_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  // Line storage; validity lives in slot_vld_q so the array needs no reset.
  always_ff @(posedge clk) begin
    if (fill_we) line_mem[beat_q] <= bus_resp;
  end

endmodule

// File: tb/tb_fetch_line_buffer.sv
// tb_fetch_line_buffer: directed checks of fetch_line_buffer with a simple bus responder.
// Define FETCH_LINE_REUSE_EN for both files to exercise the line-reuse path.
`timescale 1ns/1ps
module tb_fetch_line_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] entry = 64'h1000;
  logic        bus_reqcyc, bus_respack;
  logic [63:0] bus_req;
  logic [12:0] bus_reqtag;
  logic        bus_reqack = 1'b0, bus_respcyc = 1'b0;
  logic [63:0] bus_resp = '0;
  logic [12:0] bus_resptag = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;

  fetch_line_buffer #(.BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13)) dut (
    .clk(clk), .reset(reset), .entry(entry),
    .bus_reqcyc(bus_reqcyc), .bus_respack(bus_respack),
    .bus_req(bus_req), .bus_reqtag(bus_reqtag),
    .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc),
    .bus_resp(bus_resp), .bus_resptag(bus_resptag),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [63:0] pc; logic [31:0] ins; } cap_t;
  typedef struct { logic [63:0] exp_pc; logic [31:0] exp_instr; } vec_t;

  cap_t        caps[$];
  logic [63:0] reqs[$];
  bit          resp_en = 1'b0;
  int          ack_delay = 2;
  int          beats_sent = 0;

  // Memory image: every 32-bit word holds 0xA0000000 | its byte address.
  function automatic logic [63:0] beat_data(input logic [63:0] line, input int k);
    logic [63:0] a;
    a = line + 64'(8 * k);
    return {32'hA000_0000 | (a[31:0] + 32'd4), 32'hA000_0000 | a[31:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_reqcyc"},  64'(bus_reqcyc),  64'h0);
    chk({tag, "_respack"}, 64'(bus_respack), 64'h0);
    chk({tag, "_req"},     bus_req,          64'h0);
    chk({tag, "_reqtag"},  64'(bus_reqtag),  64'h0);
    chk({tag, "_valid"},   64'(instr_valid), 64'h0);
    chk({tag, "_instr"},   64'(instr),       64'h0);
    chk({tag, "_pc"},      instr_pc,         64'h0);
  endtask

  task automatic wait_caps(input int n, input string what);
    int t = 0;
    while (caps.size() < n && t < 300) begin @(negedge clk); #1; t++; end
    checks++;
    if (caps.size() < n) begin
      errors++;
      $display("FAIL %s: timeout with %0d instructions, expected %0d", what, caps.size(), n);
    end
  endtask

  task automatic wait_reqs(input int n, input string what);
    int t = 0;
    while (reqs.size() < n && t < 300) begin @(negedge clk); #1; t++; end
    checks++;
    if (reqs.size() < n) begin
      errors++;
      $display("FAIL %s: timeout with %0d requests, expected %0d", what, reqs.size(), n);
    end
  endtask

  task automatic do_reset(input logic [63:0] e, input logic rdy);
    @(negedge clk);
    reset = 1'b0; entry = e; redirect_valid = 1'b0; instr_ready = 1'b0;
    repeat (3) @(negedge clk);
    caps.delete(); reqs.delete(); beats_sent = 0;
    instr_ready = rdy; reset = 1'b1;
  endtask

  // Record every instruction handed over to decode.
  always @(negedge clk) begin
    #2;
    if (reset && instr_valid && instr_ready && !redirect_valid) begin
      caps.push_back('{instr_pc, instr});
      $display("instr pc=0x%0h instr=0x%0h", instr_pc, instr);
    end
  end

  // Bus responder: acks a request after ack_delay cycles, then 8 back-to-back beats.
  initial begin : responder
    logic [63:0] addr;
    bit ab;
    forever begin
      @(negedge clk); #1;
      if (resp_en && reset && bus_reqcyc) begin
        addr = bus_req;
        reqs.push_back(addr);
        ab = 1'b0;
        $display("req   addr=0x%0h", addr);
        chk("req_tag", 64'(bus_reqtag), 64'h1100);
        for (int d = 1; d < ack_delay && !ab; d++) begin
          @(negedge clk); #1;
          if (!reset) ab = 1'b1;
          else chk("req_hold", bus_req, addr);
        end
        if (!ab) begin
          @(negedge clk);
          bus_reqack = 1'b1;
          #1;
          if (!reset) ab = 1'b1;
          else chk("req_at_ack", 64'(bus_reqcyc), 64'h1);
        end
        for (int k = 0; k < 8 && !ab; k++) begin
          @(negedge clk);
          bus_reqack = 1'b0; bus_respcyc = 1'b1;
          bus_resp = beat_data(addr, k); bus_resptag = 13'h1100;
          beats_sent++;
          #1;
          if (!reset) ab = 1'b1;
          else chk("beat_ack", 64'(bus_respack), 64'h1);
        end
        if (!ab) @(negedge clk);
        bus_reqack = 1'b0; bus_respcyc = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vt[16];
    int   t;
    for (int i = 0; i < 16; i++)
      vt[i] = '{64'h1000 + 64'(4 * i), 32'hA000_1000 + 32'(4 * i)};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check_zero("reset");

    // Full line at 0x1000, ready held high
    resp_en = 1'b1; instr_ready = 1'b1; ack_delay = 2;
    @(negedge clk); reset = 1'b1;
    #1; chk("idle_no_req", 64'(bus_reqcyc), 64'h0);
    @(negedge clk); #1; chk("fetch_req", 64'(bus_reqcyc), 64'h1);
    wait_caps(16, "line_instrs");
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("seq_pc%0d", i),    caps[i].pc,         vt[i].exp_pc);
      chk($sformatf("seq_instr%0d", i), 64'(caps[i].ins),   64'(vt[i].exp_instr));
    end
    wait_reqs(2, "next_line_req");
    chk("first_req", reqs[0], 64'h1000);
    chk("next_req",  reqs[1], 64'h1040);

    // Mid-line entry
    do_reset(64'h1018, 1'b1);
    wait_caps(10, "mid_entry");
    chk("mid_req",    reqs[0], 64'h1000);
    chk("mid_pc0",    caps[0].pc, 64'h1018);
    chk("mid_instr0", 64'(caps[0].ins), 64'hA000_1018);
    chk("mid_pc9",    caps[9].pc, 64'h103C);

    // Back-pressure holds the presented instruction
    do_reset(64'h1000, 1'b0);
    t = 0;
    while (!instr_valid && t < 100) begin @(negedge clk); #1; t++; end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      chk($sformatf("stall_valid%0d", c), 64'(instr_valid), 64'h1);
      chk($sformatf("stall_pc%0d", c),    instr_pc,         64'h1000);
      chk($sformatf("stall_instr%0d", c), 64'(instr),       64'hA000_1000);
    end
    @(negedge clk); instr_ready = 1'b1;
    wait_caps(2, "stall_release");
    chk("stall_acc0", caps[0].pc, 64'h1000);
    chk("stall_acc1", caps[1].pc, 64'h1004);

    // Redirect mid-fill drains the remaining beats
    do_reset(64'h1000, 1'b0);
    t = 0;
    while (beats_sent < 3 && t < 100) begin @(negedge clk); #1; t++; end
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 64'h2004;
    @(negedge clk); redirect_valid = 1'b0; instr_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1; chk($sformatf("drain_valid%0d", c), 64'(instr_valid), 64'h0);
      @(negedge clk);
    end
    wait_reqs(2, "redirect_req");
    chk("redirect_req_addr", reqs[1], 64'h2000);
    wait_caps(1, "redirect_instr");
    chk("redirect_pc0",    caps[0].pc, 64'h2004);
    chk("redirect_instr0", 64'(caps[0].ins), 64'hA000_2004);

    // Redirect into the complete buffered line
    do_reset(64'h1000, 1'b0);
    t = 0;
    while (beats_sent < 8 && t < 100) begin @(negedge clk); #1; t++; end
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 64'h1008;
    @(negedge clk); redirect_valid = 1'b0; instr_ready = 1'b1;
    #1;
`ifdef FETCH_LINE_REUSE_EN
    chk("reuse_no_req", 64'(bus_reqcyc),  64'h0);
    chk("reuse_valid",  64'(instr_valid), 64'h1);
    chk("reuse_pc",     instr_pc,         64'h1008);
    chk("reuse_instr",  64'(instr),       64'hA000_1008);
`else
    chk("refetch_valid", 64'(instr_valid), 64'h0);
    wait_reqs(2, "refetch_req");
    chk("refetch_addr", reqs[1], 64'h1000);
`endif
    wait_caps(1, "reuse_instr");
    chk("reuse_first_pc", caps[0].pc, 64'h1008);

    // Reset in the middle of a fill, with a beat on the bus
    resp_en = 1'b0;
    do_reset(64'h1000, 1'b0);
    t = 0;
    while (!bus_reqcyc && t < 100) begin @(negedge clk); #1; t++; end
    chk("rst_fill_req", bus_req, 64'h1000);
    @(negedge clk); bus_reqack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus_reqack = 1'b0; bus_respcyc = 1'b1; bus_resp = beat_data(64'h1000, k);
    end
    @(negedge clk);
    bus_resp = beat_data(64'h1000, 5); reset = 1'b0; entry = 64'h4040;
    #1;
    check_zero("midfill_rst");
    @(negedge clk); bus_respcyc = 1'b0;
    repeat (2) @(negedge clk);
    caps.delete(); reqs.delete(); beats_sent = 0;
    resp_en = 1'b1; instr_ready = 1'b1; reset = 1'b1;
    wait_reqs(1, "post_rst_req");
    chk("post_rst_addr", reqs[0], 64'h4040);
    wait_caps(1, "post_rst_instr");
    chk("post_rst_pc", caps[0].pc, 64'h4040);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
